// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating one-hot row drive, synchronized column
// sampling, press/release debounce and hex key encoding.
module keypad_scanner #(
   parameter int unsigned SCAN_HOLD = 4,
   parameter int unsigned DEBOUNCE  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

   state_t      state, next_state;
   logic [3:0]  c_meta, cols_s;
   logic [1:0]  row_idx, col_idx, hit_col;
   logic [7:0]  slot_cnt;
   logic [15:0] deb_cnt, deb_inc;
   logic        slot_end, sample, deb_done;
   logic [3:0]  map_code;

   assign slot_end = (slot_cnt == 8'(SCAN_HOLD - 1));
   assign sample   = cols_s[col_idx];
   assign deb_done = (({1'b0, deb_cnt} + 17'd1) >= 17'(DEBOUNCE));
   assign deb_inc  = (deb_cnt == '1) ? deb_cnt : deb_cnt + 16'd1;

   always_comb begin
      hit_col = 2'd0;
      if (cols_s[0])      hit_col = 2'd0;
      else if (cols_s[1]) hit_col = 2'd1;
      else if (cols_s[2]) hit_col = 2'd2;
      else if (cols_s[3]) hit_col = 2'd3;
   end

   always_comb begin
      map_code = 4'h0;
      case ({row_idx, col_idx})
         4'b00_00: map_code = 4'h1;
         4'b00_01: map_code = 4'h2;
         4'b00_10: map_code = 4'h3;
         4'b00_11: map_code = 4'hA;
         4'b01_00: map_code = 4'h4;
         4'b01_01: map_code = 4'h5;
         4'b01_10: map_code = 4'h6;
         4'b01_11: map_code = 4'hB;
         4'b10_00: map_code = 4'h7;
         4'b10_01: map_code = 4'h8;
         4'b10_10: map_code = 4'h9;
         4'b10_11: map_code = 4'hC;
         4'b11_00: map_code = 4'hE;
         4'b11_01: map_code = 4'h0;
         4'b11_10: map_code = 4'hF;
         4'b11_11: map_code = 4'hD;
         default:  map_code = 4'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_SCAN;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_SCAN:     if (slot_end && (cols_s != '0)) next_state = S_DEBOUNCE;
         S_DEBOUNCE: if (!sample) next_state = S_SCAN;
                     else if (deb_done) next_state = S_HELD;
         S_HELD:     if (!sample) next_state = S_RELEASE;
         S_RELEASE:  if (sample) next_state = S_HELD;
                     else if (deb_done) next_state = S_SCAN;
         default:    next_state = S_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_meta    <= '0;
         cols_s    <= '0;
         row_idx   <= '0;
         col_idx   <= '0;
         slot_cnt  <= '0;
         deb_cnt   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         c_meta    <= cols;
         cols_s    <= c_meta;
         key_valid <= 1'b0;
         case (state)
            S_SCAN: begin
               if (slot_end) begin
                  slot_cnt <= '0;
                  if (cols_s != '0) col_idx <= hit_col;
                  else              row_idx <= row_idx + 2'd1;
               end else begin
                  slot_cnt <= slot_cnt + 8'd1;
               end
            end
            S_DEBOUNCE: begin
               if (!sample) begin
                  row_idx  <= row_idx + 2'd1;
                  slot_cnt <= '0;
                  deb_cnt  <= '0;
               end else if (deb_done) begin
                  key_valid <= 1'b1;
                  key_code  <= map_code;
                  deb_cnt   <= '0;
               end else begin
                  deb_cnt <= deb_inc;
               end
            end
            // The low sample that leaves HELD is the first of the release run.
            S_HELD: deb_cnt <= sample ? 16'd0 : 16'd1;
            S_RELEASE: begin
               if (sample) begin
                  deb_cnt <= '0;
               end else if (deb_done) begin
                  row_idx  <= row_idx + 2'd1;
                  slot_cnt <= '0;
                  deb_cnt  <= '0;
               end else begin
                  deb_cnt <= deb_inc;
               end
            end
            default: deb_cnt <= '0;
         endcase
      end
   end

   always_comb begin
      rows     = 4'b0001 << row_idx;
      key_held = (state == S_HELD) || (state == S_RELEASE);
   end

endmodule
